// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between two req/ack masters and sequences the memread/memwrite + clk_stall handshake.
// Latency: ack 5 cycles after req is first sampled; clk_stall stuck high aborts with err after TIMEOUT cycles.
module dmem_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_sign_mask,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_sign_mask,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memread,
    output logic        mem_memwrite,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP} state_t;

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             gnt;
    logic             last_grant;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             win;
    logic             any_req;
    logic             done;
    logic [31:0]      resp_data;

    always_comb begin
        any_req = m0_req | m1_req;
        // On a tie the master that was not served last wins, unless master 0 has fixed priority
        if (m0_req && m1_req)
            win = (ARB_MODE == 1) ? 1'b0 : ~last_grant;
        else
            win = ~m0_req;
        cnt_inc   = cnt + CNT_ONE;
        done      = ~mem_clk_stall | (cnt_inc == TO_VAL);
        resp_data = (mem_clk_stall | we_q) ? 32'h0 : mem_read_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            last_grant     <= 1'b1;
            we_q           <= 1'b0;
            cnt            <= '0;
            mem_addr       <= 32'h0;
            mem_write_data <= 32'h0;
            mem_sign_mask  <= 4'h0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            m0_rdata       <= 32'h0;
            m0_ack         <= 1'b0;
            m0_err         <= 1'b0;
            m1_rdata       <= 32'h0;
            m1_ack         <= 1'b0;
            m1_err         <= 1'b0;
        end else begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            case (state)
                IDLE: begin
                    // A memory still stalling from a pre-reset transaction must finish before any grant
                    if (any_req && !mem_clk_stall) begin
                        gnt            <= win;
                        last_grant     <= win;
                        we_q           <= win ? m1_we : m0_we;
                        mem_addr       <= win ? m1_addr : m0_addr;
                        mem_write_data <= win ? m1_wdata : m0_wdata;
                        mem_sign_mask  <= win ? m1_sign_mask : m0_sign_mask;
                        mem_memread    <= win ? ~m1_we : ~m0_we;
                        mem_memwrite   <= win ? m1_we : m0_we;
                        state          <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT_HI;
                WAIT_HI: begin
                    cnt   <= '0;
                    state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (mem_clk_stall)
                        cnt <= cnt_inc;
                    if (done) begin
                        state <= RESP;
                        if (gnt) begin
                            m1_ack   <= 1'b1;
                            m1_err   <= mem_clk_stall;
                            m1_rdata <= resp_data;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_err   <= mem_clk_stall;
                            m0_rdata <= resp_data;
                        end
                    end
                end
                RESP: begin
                    mem_addr       <= 32'h0;
                    mem_write_data <= 32'h0;
                    mem_sign_mask  <= 4'h0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance 0 round-robin, instance 1 fixed priority,
// each with its own memory model that stalls two cycles per access or hangs on demand.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 15;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
        int          tack;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        m0_req [2], m0_we [2], m0_ack [2], m0_err [2];
    logic [31:0] m0_addr [2], m0_wdata [2], m0_rdata [2];
    logic [3:0]  m0_sign_mask [2];
    logic        m1_req [2], m1_we [2], m1_ack [2], m1_err [2];
    logic [31:0] m1_addr [2], m1_wdata [2], m1_rdata [2];
    logic [3:0]  m1_sign_mask [2];
    logic [31:0] mem_addr [2], mem_write_data [2];
    logic        mem_memread [2], mem_memwrite [2];
    logic [3:0]  mem_sign_mask [2];

    bit [31:0] mem [2][64];
    bit        valid [2][64];
    bit [31:0] rd [2];
    bit        stall_m [2];
    int        scnt [2];
    bit        hang [2];

    exp_t        sb [$];
    int          cyc, n_chk, n_pass;
    int          strobes, strobe_cyc, n_ack0;
    logic [31:0] strobe_addr;
    logic [3:0]  strobe_mask;
    logic        strobe_rd;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.ARB_MODE(g), .TIMEOUT(TIMEOUT), .CNT_W(4)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n[g]),
            .m0_req         (m0_req[g]),
            .m0_we          (m0_we[g]),
            .m0_addr        (m0_addr[g]),
            .m0_wdata       (m0_wdata[g]),
            .m0_sign_mask   (m0_sign_mask[g]),
            .m0_rdata       (m0_rdata[g]),
            .m0_ack         (m0_ack[g]),
            .m0_err         (m0_err[g]),
            .m1_req         (m1_req[g]),
            .m1_we          (m1_we[g]),
            .m1_addr        (m1_addr[g]),
            .m1_wdata       (m1_wdata[g]),
            .m1_sign_mask   (m1_sign_mask[g]),
            .m1_rdata       (m1_rdata[g]),
            .m1_ack         (m1_ack[g]),
            .m1_err         (m1_err[g]),
            .mem_addr       (mem_addr[g]),
            .mem_write_data (mem_write_data[g]),
            .mem_memread    (mem_memread[g]),
            .mem_memwrite   (mem_memwrite[g]),
            .mem_sign_mask  (mem_sign_mask[g]),
            .mem_read_data  (rd[g]),
            .mem_clk_stall  (stall_m[g])
        );
    end

    // Memory model: unwritten word 1 (0x1004) reads DEADBEEF, other unwritten words 0BADF00D
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_memread[d] || mem_memwrite[d]) begin
                if (mem_memwrite[d]) begin
                    mem[d][mem_addr[d][7:2]]   <= mem_write_data[d];
                    valid[d][mem_addr[d][7:2]] <= 1'b1;
                end
                rd[d] <= valid[d][mem_addr[d][7:2]] ? mem[d][mem_addr[d][7:2]] :
                         (mem_addr[d][7:2] == 6'd1) ? 32'hDEADBEEF : 32'h0BADF00D;
                stall_m[d] <= 1'b1;
                scnt[d]    <= hang[d] ? 0 : 2;
            end else if (scnt[d] > 0) begin
                scnt[d] <= scnt[d] - 1;
                if (scnt[d] == 1)
                    stall_m[d] <= 1'b0;
            end else if (!hang[d]) begin
                stall_m[d] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic note_strobe(input int d);
        if (mem_memread[d] || mem_memwrite[d]) begin
            strobes     = strobes + 1;
            strobe_cyc  = cyc;
            strobe_addr = mem_addr[d];
            strobe_mask = mem_sign_mask[d];
            strobe_rd   = mem_memread[d];
            chk("strobe_excl", {31'b0, mem_memread[d] & mem_memwrite[d]}, 32'h0);
        end
    endtask

    task automatic next_ack(input int d);
        bit   got;
        logic who;
        exp_t e;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step();
            note_strobe(d);
            if (m0_ack[d] || m1_ack[d]) begin
                got = 1'b1;
                who = m1_ack[d];
                if (!who) n_ack0 = n_ack0 + 1;
                chk("one_ack", {31'b0, m0_ack[d] & m1_ack[d]}, 32'h0);
                if (sb.size() == 0) begin
                    n_chk = n_chk + 1;
                    $error("FAIL sb_unexpected_ack: observed master %0d, expected none", who);
                end else begin
                    e = sb.pop_front();
                    chk("ack_master", {31'b0, who}, e.m);
                    chk("ack_rdata", who ? m1_rdata[d] : m0_rdata[d], e.rdata);
                    chk("ack_err", {31'b0, who ? m1_err[d] : m0_err[d]}, {31'b0, e.err});
                    chk("ack_cycle", cyc, e.tack);
                end
            end
        end
        if (!got) begin
            n_chk = n_chk + 1;
            $error("FAIL ack_wait: observed no ack within 60 cycles, expected ack at %0d", cyc);
        end
    endtask

    initial begin
        int t0;
        cyc = 0; n_chk = 0; n_pass = 0; strobes = 0; strobe_cyc = 0; n_ack0 = 0;
        strobe_addr = '0; strobe_mask = '0; strobe_rd = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; hang[d] = 1'b0;
            m0_req[d] = 0; m0_we[d] = 0; m0_addr[d] = 0; m0_wdata[d] = 0; m0_sign_mask[d] = 0;
            m1_req[d] = 0; m1_we[d] = 0; m1_addr[d] = 0; m1_wdata[d] = 0; m1_sign_mask[d] = 0;
        end
        repeat (3) step();
        chk("rst_mem_addr", mem_addr[0], 32'h0);
        chk("rst_memread", {31'b0, mem_memread[0]}, 32'h0);
        chk("rst_acks", {30'b0, m0_ack[0], m1_ack[0]}, 32'h0);
        chk("rst_rdata", m0_rdata[1], 32'h0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        step();

        // Single load from master 0
        m0_addr[0] = 32'h1004; m0_sign_mask[0] = 4'b0100;
        strobes = 0; t0 = cyc;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 5});
        m0_req[0] = 1'b1;
        next_ack(0);
        m0_req[0] = 1'b0;
        chk("load_strobes", strobes, 1);
        chk("load_strobe_cyc", strobe_cyc, t0 + 1);
        chk("load_addr", strobe_addr, 32'h1004);
        chk("load_mask", {28'b0, strobe_mask}, 32'h4);
        chk("load_is_read", {31'b0, strobe_rd}, 32'h1);
        step();
        chk("idle_addr", mem_addr[0], 32'h0);
        chk("rdata_hold", m0_rdata[0], 32'hDEADBEEF);

        // Master 1 store then load back
        n_ack0 = 0;
        m1_we[0] = 1'b1; m1_addr[0] = 32'h1010; m1_wdata[0] = 32'h12345678; m1_sign_mask[0] = 4'b1111;
        t0 = cyc;
        sb.push_back('{1, 32'h0, 1'b0, t0 + 5});
        m1_req[0] = 1'b1;
        next_ack(0);
        m1_req[0] = 1'b0;
        chk("store_is_write", {31'b0, strobe_rd}, 32'h0);
        step();
        m1_we[0] = 1'b0;
        t0 = cyc;
        sb.push_back('{1, 32'h12345678, 1'b0, t0 + 5});
        m1_req[0] = 1'b1;
        next_ack(0);
        m1_req[0] = 1'b0;
        chk("no_m0_ack", n_ack0, 0);
        step();

        // Round-robin contention, both held high for 4 transactions
        t0 = cyc;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 5});
        sb.push_back('{1, 32'h12345678, 1'b0, t0 + 11});
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 17});
        sb.push_back('{1, 32'h12345678, 1'b0, t0 + 23});
        m0_req[0] = 1'b1; m1_req[0] = 1'b1;
        repeat (4) next_ack(0);
        m0_req[0] = 1'b0; m1_req[0] = 1'b0;
        step();

        // Fixed priority: master 0 served three times, master 1 only after m0 drops
        m0_addr[1] = 32'h1004; m1_addr[1] = 32'h1010;
        t0 = cyc;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 5});
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 11});
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 17});
        sb.push_back('{1, 32'h0BADF00D, 1'b0, t0 + 23});
        m0_req[1] = 1'b1; m1_req[1] = 1'b1;
        repeat (3) next_ack(1);
        m0_req[1] = 1'b0;
        next_ack(1);
        m1_req[1] = 1'b0;
        step();

        // Timeout: memory never drops stall
        hang[0] = 1'b1;
        t0 = cyc;
        sb.push_back('{0, 32'h0, 1'b1, t0 + 2 + TIMEOUT + 1});
        m0_req[0] = 1'b1;
        next_ack(0);
        strobes = 0;
        repeat (10) begin
            step();
            note_strobe(0);
        end
        chk("no_issue_stalled", strobes, 0);
        chk("idle_after_to", mem_addr[0], 32'h0);
        hang[0] = 1'b0;
        t0 = cyc; strobes = 0;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 6});
        next_ack(0);
        m0_req[0] = 1'b0;
        chk("post_to_strobe_cyc", strobe_cyc, t0 + 2);
        step();

        // Reset during WAIT_LO with memory still stalling afterwards
        hang[0] = 1'b1;
        m0_req[0] = 1'b1;
        repeat (4) step();
        rst_n[0] = 1'b0;
        #1;
        chk("arst_addr", mem_addr[0], 32'h0);
        chk("arst_rdata", m0_rdata[0], 32'h0);
        chk("arst_flags", {27'b0, m0_ack[0], m1_ack[0], m0_err[0], mem_memread[0], mem_memwrite[0]}, 32'h0);
        step();
        rst_n[0] = 1'b1;
        t0 = cyc; strobes = 0;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, t0 + 7});
        step();
        note_strobe(0);
        hang[0] = 1'b0;
        next_ack(0);
        m0_req[0] = 1'b0;
        chk("post_rst_strobes", strobes, 1);
        chk("post_rst_strobe_cyc", strobe_cyc, t0 + 3);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the data memory.
- Shares the single data-memory port between master 0 (CPU load/store path) and master 1 (debug/DMA port).
- Converts each master's req/ack handshake into the memory's one-cycle memread/memwrite strobe plus clk_stall completion protocol.
- Returns read data and an error flag to the granted master.

Parameters:
ARB_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 0 always wins.
TIMEOUT, 15, max cycles clk_stall may stay high in WAIT_LO before the transaction is aborted with error.
CNT_W, 4, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request, held high until m0_ack
m0_we  in  1  master 0: 1 = store, 0 = load
m0_addr  in  32  master 0 byte address
m0_wdata  in  32  master 0 store data
m0_sign_mask  in  4  master 0 size/sign mask, passed through unchanged
m0_rdata  out  32  master 0 load data, valid when m0_ack=1
m0_ack  out  1  one-cycle completion pulse to master 0
m0_err  out  1  timeout flag, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_sign_mask, m1_rdata, m1_ack, m1_err  as m0_*, for master 1
mem_addr  out  32  to memory addr
mem_write_data  out  32  to memory write_data
mem_memread  out  1  to memory memread
mem_memwrite  out  1  to memory memwrite
mem_sign_mask  out  4  to memory sign_mask
mem_read_data  in  32  from memory read_data
mem_clk_stall  in  1  from memory clk_stall

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0.
  - last_grant = 1, so master 0 wins the first tie.
  - Timeout counter 0; captured rdata 0.
- States: IDLE, ISSUE, WAIT_HI, WAIT_LO, RESP.
- IDLE:
  - Grants only when some req=1 and mem_clk_stall=0.
  - The stall guard covers a memory still finishing a transaction after a mid-operation reset.
  - Grant rule:
    - One requester: it wins.
    - Both requesting, ARB_MODE=0: the master other than last_grant wins.
    - Both requesting, ARB_MODE=1: master 0 wins.
  - On grant: latch grant index, addr, wdata, we, sign_mask into internal registers; update last_grant; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive mem_addr, mem_write_data, mem_sign_mask from the latched registers.
  - mem_memread = ~we and mem_memwrite = we, for this cycle only. Go to WAIT_HI.
- mem_addr, mem_write_data and mem_sign_mask hold their latched values from ISSUE through RESP; they are 0 in IDLE.
- mem_memread and mem_memwrite are never both 1, and are 0 outside ISSUE.
- WAIT_HI (1 cycle):
  - Expects mem_clk_stall=1.
  - Go to WAIT_LO regardless; clear the timeout counter.
- WAIT_LO:
  - If mem_clk_stall=0: capture mem_read_data (for loads; hold 0 for stores); err=0; go to RESP.
  - Else increment the counter. If the counter reaches TIMEOUT: err=1, rdata=0, go to RESP.
- RESP (1 cycle):
  - Pulse the granted master's ack=1 with rdata and err; the other master's ack stays 0.
  - Go to IDLE. A new grant may occur in the next IDLE cycle.
- Nominal latency: req first sampled high at edge N → ISSUE in cycle N+1 → ack high in cycle N+5 (WAIT_HI 1 cycle, WAIT_LO 2 cycles). Loads and stores take the same time.
- rdata outputs hold their last value between acks; err is meaningful only with ack.
- A req dropped before ack is a protocol violation. The transaction still completes; ack is still pulsed.
- A master re-asserting req in the ack cycle is treated as a new request at the next IDLE.
- Address decoding and the LED register at 0x2000 are untouched: addresses pass through unmodified.

Test Plan:
- Single load: m0_req=1, we=0, addr=0x1004, sign_mask=4'b0100 → one mem_memread pulse with mem_addr=0x1004; m0_ack in cycle N+5 with m0_rdata = stored word 0xDEADBEEF; m0_err=0.
- Single store then load: m1 store word 0x12345678 to 0x1010, then m1 load from 0x1010 → second ack returns 0x12345678; m0_ack never pulses.
- Contention, ARB_MODE=0: m0_req and m1_req held high together for 4 transactions → grant order 0,1,0,1; at most one ack per cycle; each ack ≥5 cycles apart.
- Contention, ARB_MODE=1: both held high for 3 transactions → master 0 served all 3; m1 served only after m0_req drops.
- Timeout: memory model holds mem_clk_stall=1 forever after issue → ack with err=1, rdata=0 exactly TIMEOUT cycles into WAIT_LO; arbiter back in IDLE; no new issue while stall remains high.
- Reset mid-transaction: assert rst_n=0 during WAIT_LO → all outputs 0 immediately; after release with mem_clk_stall still high for 2 cycles, a pending m0_req is issued only after mem_clk_stall falls.
